// File: rtl/rv_mem_pkg.sv
// Shared definitions for the MEM stage: load/store type encodings, the
// access FSM state type and small lane helpers (byte enables, store data
// replication, alignment check).
package rv_mem_pkg;

  localparam logic [2:0] LOAD_LB  = 3'b000;
  localparam logic [2:0] LOAD_LH  = 3'b001;
  localparam logic [2:0] LOAD_LW  = 3'b010;
  localparam logic [2:0] LOAD_LBU = 3'b100;
  localparam logic [2:0] LOAD_LHU = 3'b101;

  localparam logic [1:0] STORE_SB = 2'b00;
  localparam logic [1:0] STORE_SH = 2'b01;
  localparam logic [1:0] STORE_SW = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_REQ      = 2'b01,
    ST_WAIT_RSP = 2'b10
  } mem_state_e;

  // Byte enables for a store; store_type 11 falls through to the word case.
  function automatic logic [3:0] store_be(input logic [1:0] st, input logic [1:0] addr_lo);
    case (st)
      STORE_SB: store_be = 4'b0001 << addr_lo;
      STORE_SH: store_be = 4'b0011 << {addr_lo[1], 1'b0};
      default:  store_be = 4'b1111;
    endcase
  endfunction

  // Replicate the store operand across every lane it could land in.
  function automatic logic [31:0] store_wdata(input logic [1:0] st, input logic [31:0] d);
    case (st)
      STORE_SB: store_wdata = {4{d[7:0]}};
      STORE_SH: store_wdata = {2{d[15:0]}};
      default:  store_wdata = d;
    endcase
  endfunction

  // Undefined load types behave as LW, undefined store type as SW.
  function automatic logic is_misaligned(input logic is_store, input logic [2:0] lt,
                                         input logic [1:0] st, input logic [1:0] addr_lo);
    logic mis;
    if (is_store) begin
      case (st)
        STORE_SB: mis = 1'b0;
        STORE_SH: mis = addr_lo[0];
        default:  mis = (addr_lo != 2'b00);
      endcase
    end else begin
      case (lt)
        LOAD_LB, LOAD_LBU: mis = 1'b0;
        LOAD_LH, LOAD_LHU: mis = addr_lo[0];
        default:           mis = (addr_lo != 2'b00);
      endcase
    end
    is_misaligned = mis;
  endfunction

endpackage

// File: rtl/load_align_ext.sv
// Selects the addressed byte/half of a read word and sign- or zero-extends it.
// Ports: rdata_i (raw word), addr_lo_i (address bits [1:0]), load_type_i,
//        data_o (extended 32-bit load value). Purely combinational.
module load_align_ext
  import rv_mem_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  load_type_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane select followed by extension.
  always_comb begin
    case (addr_lo_i)
      2'b00:   byte_s = rdata_i[7:0];
      2'b01:   byte_s = rdata_i[15:8];
      2'b10:   byte_s = rdata_i[23:16];
      default: byte_s = rdata_i[31:24];
    endcase
    if (addr_lo_i[1]) begin
      half_s = rdata_i[31:16];
    end else begin
      half_s = rdata_i[15:0];
    end
    case (load_type_i)
      LOAD_LB:  data_o = {{24{byte_s[7]}}, byte_s};
      LOAD_LBU: data_o = {24'h000000, byte_s};
      LOAD_LH:  data_o = {{16{half_s[15]}}, half_s};
      LOAD_LHU: data_o = {16'h0000, half_s};
      default:  data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage. Holds the EX/MEM register, runs a req/gnt/rvalid data
// memory transaction for loads and stores, and registers the MEM/WB result.
// Ports: clk/rst_n (sync active-low); *_ex / *_ex_out EX-stage inputs;
//        stall_o, data_forward_mem, rd_mem, wb_reg_file_mem back to EX/hazard;
//        dmem_* memory request/response; wb_* MEM/WB register;
//        misaligned_exc / bus_err single-cycle error pulses.
module mem_access_stage
  import rv_mem_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] alu_result_ex,
  input  logic [XLEN-1:0] rs2_data_for_mem_ex,
  input  logic [4:0]      rd_ex_out,
  input  logic            mem_write_ex_out,
  input  logic            memtoreg_ex_out,
  input  logic [2:0]      mem_load_type_ex_out,
  input  logic [1:0]      mem_store_type_ex_out,
  input  logic            wb_reg_file_ex_out,
  output logic            stall_o,
  output logic [XLEN-1:0] data_forward_mem,
  output logic [4:0]      rd_mem,
  output logic            wb_reg_file_mem,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [3:0]      dmem_be,
  input  logic            dmem_gnt,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            wb_valid,
  output logic [4:0]      wb_rd,
  output logic            wb_we,
  output logic [XLEN-1:0] wb_data,
  output logic            misaligned_exc,
  output logic            bus_err
);

  // Abort fires on the busy cycle that would make the count reach TIMEOUT_CYC.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);

  mem_state_e state_q, state_d;
  logic [7:0] tmo_q, tmo_d;

  logic            exm_valid_q, exm_valid_d;
  logic [XLEN-1:0] exm_alu_q, exm_alu_d;
  logic [XLEN-1:0] exm_sdata_q, exm_sdata_d;
  logic [4:0]      exm_rd_q, exm_rd_d;
  logic            exm_we_q, exm_we_d;
  logic            exm_ld_q, exm_ld_d;
  logic [2:0]      exm_lt_q, exm_lt_d;
  logic [1:0]      exm_st_q, exm_st_d;
  logic            exm_wbrf_q, exm_wbrf_d;

  logic            wb_valid_q, wb_valid_d;
  logic [4:0]      wb_rd_q, wb_rd_d;
  logic            wb_we_q, wb_we_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;
  logic            mis_q, mis_d;
  logic            berr_q, berr_d;

  logic            entry_mem_s, entry_mis_s, access_s;
  logic            req_phase_s, wait_phase_s, busy_s;
  logic            done_s, abort_s, finish_s, retire_s;
  logic [XLEN-1:0] load_val_s;

  load_align_ext u_load_align_ext (
    .rdata_i     (dmem_rdata),
    .addr_lo_i   (exm_alu_q[1:0]),
    .load_type_i (exm_lt_q),
    .data_o      (load_val_s)
  );

  // Transaction control: phase decode, completion/abort, stall and next state.
  always_comb begin
    entry_mem_s  = exm_valid_q & (exm_we_q | exm_ld_q);
    entry_mis_s  = entry_mem_s & is_misaligned(exm_we_q, exm_lt_q, exm_st_q, exm_alu_q[1:0]);
    access_s     = entry_mem_s & ~entry_mis_s;
    // A fresh entry in IDLE is already its first request cycle.
    req_phase_s  = access_s & ((state_q == ST_IDLE) | (state_q == ST_REQ));
    wait_phase_s = access_s & (state_q == ST_WAIT_RSP);
    busy_s       = req_phase_s | wait_phase_s;
    // A load granted with rvalid in the same cycle completes immediately.
    done_s       = (req_phase_s & dmem_gnt & (exm_we_q | dmem_rvalid)) |
                   (wait_phase_s & dmem_rvalid);
    abort_s      = busy_s & ~done_s & (tmo_q == TMO_LAST);
    finish_s     = done_s | abort_s;
    stall_o      = busy_s & ~finish_s;
    retire_s     = (exm_valid_q & ~entry_mem_s) | entry_mis_s | finish_s;

    if (~busy_s | finish_s) begin
      tmo_d = 8'd0;
    end else begin
      tmo_d = tmo_q + 8'd1;
    end

    case (state_q)
      ST_IDLE, ST_REQ: begin
        if (~access_s | finish_s) begin
          state_d = ST_IDLE;
        end else if (dmem_gnt) begin
          state_d = ST_WAIT_RSP;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_WAIT_RSP: begin
        if (~access_s | finish_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT_RSP;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Memory interface; lanes are gated to zero when no access is pending.
  always_comb begin
    dmem_req  = req_phase_s;
    dmem_we   = req_phase_s & exm_we_q;
    dmem_addr = {exm_alu_q[XLEN-1:2], 2'b00};
    if (access_s & exm_we_q) begin
      dmem_be    = store_be(exm_st_q, exm_alu_q[1:0]);
      dmem_wdata = store_wdata(exm_st_q, exm_sdata_q);
    end else if (access_s) begin
      dmem_be    = 4'b1111;
      dmem_wdata = '0;
    end else begin
      dmem_be    = 4'b0000;
      dmem_wdata = '0;
    end
  end

  // EX/MEM next value: hold while stalled, otherwise capture EX or a bubble.
  always_comb begin
    if (stall_o) begin
      exm_valid_d = exm_valid_q;
      exm_alu_d   = exm_alu_q;
      exm_sdata_d = exm_sdata_q;
      exm_rd_d    = exm_rd_q;
      exm_we_d    = exm_we_q;
      exm_ld_d    = exm_ld_q;
      exm_lt_d    = exm_lt_q;
      exm_st_d    = exm_st_q;
      exm_wbrf_d  = exm_wbrf_q;
    end else if (ex_valid) begin
      exm_valid_d = 1'b1;
      exm_alu_d   = alu_result_ex;
      exm_sdata_d = rs2_data_for_mem_ex;
      exm_rd_d    = rd_ex_out;
      exm_we_d    = mem_write_ex_out;
      exm_ld_d    = memtoreg_ex_out;
      exm_lt_d    = mem_load_type_ex_out;
      exm_st_d    = mem_store_type_ex_out;
      exm_wbrf_d  = wb_reg_file_ex_out;
    end else begin
      exm_valid_d = 1'b0;
      exm_alu_d   = '0;
      exm_sdata_d = '0;
      exm_rd_d    = 5'd0;
      exm_we_d    = 1'b0;
      exm_ld_d    = 1'b0;
      exm_lt_d    = 3'b000;
      exm_st_d    = 2'b00;
      exm_wbrf_d  = 1'b0;
    end
  end

  // MEM/WB next value; errored entries retire with the write suppressed.
  always_comb begin
    wb_valid_d = retire_s;
    wb_rd_d    = exm_rd_q;
    wb_we_d    = retire_s & exm_wbrf_q & (exm_rd_q != 5'd0) & ~entry_mis_s & ~abort_s;
    if (exm_ld_q & ~exm_we_q & done_s) begin
      wb_data_d = load_val_s;
    end else begin
      wb_data_d = exm_alu_q;
    end
    mis_d  = entry_mis_s;
    berr_d = abort_s;
  end

  // All state, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      tmo_q       <= 8'd0;
      exm_valid_q <= 1'b0;
      exm_alu_q   <= '0;
      exm_sdata_q <= '0;
      exm_rd_q    <= 5'd0;
      exm_we_q    <= 1'b0;
      exm_ld_q    <= 1'b0;
      exm_lt_q    <= 3'b000;
      exm_st_q    <= 2'b00;
      exm_wbrf_q  <= 1'b0;
      wb_valid_q  <= 1'b0;
      wb_rd_q     <= 5'd0;
      wb_we_q     <= 1'b0;
      wb_data_q   <= '0;
      mis_q       <= 1'b0;
      berr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmo_q       <= tmo_d;
      exm_valid_q <= exm_valid_d;
      exm_alu_q   <= exm_alu_d;
      exm_sdata_q <= exm_sdata_d;
      exm_rd_q    <= exm_rd_d;
      exm_we_q    <= exm_we_d;
      exm_ld_q    <= exm_ld_d;
      exm_lt_q    <= exm_lt_d;
      exm_st_q    <= exm_st_d;
      exm_wbrf_q  <= exm_wbrf_d;
      wb_valid_q  <= wb_valid_d;
      wb_rd_q     <= wb_rd_d;
      wb_we_q     <= wb_we_d;
      wb_data_q   <= wb_data_d;
      mis_q       <= mis_d;
      berr_q      <= berr_d;
    end
  end

  assign data_forward_mem = exm_alu_q;
  assign rd_mem           = exm_rd_q;
  assign wb_reg_file_mem  = exm_valid_q & exm_wbrf_q;
  assign wb_valid         = wb_valid_q;
  assign wb_rd            = wb_rd_q;
  assign wb_we            = wb_we_q;
  assign wb_data          = wb_data_q;
  assign misaligned_exc   = mis_q;
  assign bus_err          = berr_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with hand-computed expected values.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid;
  logic [31:0] alu_result_ex, rs2_data_for_mem_ex;
  logic [4:0]  rd_ex_out;
  logic        mem_write_ex_out, memtoreg_ex_out, wb_reg_file_ex_out;
  logic [2:0]  mem_load_type_ex_out;
  logic [1:0]  mem_store_type_ex_out;
  logic        stall_o;
  logic [31:0] data_forward_mem;
  logic [4:0]  rd_mem;
  logic        wb_reg_file_mem;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        wb_valid, wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        misaligned_exc, bus_err;

  int n_total = 0;
  int n_bad   = 0;

  logic        cap_req, cap_we;
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_be;
  int          stalls;

  mem_access_stage #(.XLEN(32), .TIMEOUT_CYC(255)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid),
    .alu_result_ex(alu_result_ex), .rs2_data_for_mem_ex(rs2_data_for_mem_ex),
    .rd_ex_out(rd_ex_out), .mem_write_ex_out(mem_write_ex_out),
    .memtoreg_ex_out(memtoreg_ex_out), .mem_load_type_ex_out(mem_load_type_ex_out),
    .mem_store_type_ex_out(mem_store_type_ex_out), .wb_reg_file_ex_out(wb_reg_file_ex_out),
    .stall_o(stall_o), .data_forward_mem(data_forward_mem), .rd_mem(rd_mem),
    .wb_reg_file_mem(wb_reg_file_mem), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
    .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_we(wb_we), .wb_data(wb_data),
    .misaligned_exc(misaligned_exc), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Advance to 2 time units after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Present one instruction for a single cycle; returns in its first MEM cycle.
  task automatic issue(input logic [31:0] alu, input logic [31:0] sdata, input logic [4:0] rd,
                       input logic we, input logic ld, input logic [2:0] lt,
                       input logic [1:0] st, input logic wbrf);
    alu_result_ex = alu; rs2_data_for_mem_ex = sdata; rd_ex_out = rd;
    mem_write_ex_out = we; memtoreg_ex_out = ld; mem_load_type_ex_out = lt;
    mem_store_type_ex_out = st; wb_reg_file_ex_out = wbrf; ex_valid = 1'b1;
    tick();
    ex_valid = 1'b0;
  endtask

  // Drive gnt at cycle gd and rvalid at cycle gd+rl (negative = never).
  // Captures the first-cycle request, counts stall cycles, returns the cycle after retirement.
  task automatic run_mem(input int gd, input int rl, input logic [31:0] rdat, output int n_stall);
    bit fin;
    n_stall = 0;
    fin = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      dmem_gnt    = (gd >= 0) && (cyc == gd);
      dmem_rvalid = (gd >= 0) && (rl >= 0) && (cyc == gd + rl);
      dmem_rdata  = rdat;
      #3;
      if (cyc == 0) begin
        cap_req = dmem_req; cap_we = dmem_we; cap_addr = dmem_addr;
        cap_wdata = dmem_wdata; cap_be = dmem_be;
      end
      if (stall_o) n_stall++;
      fin = !stall_o;
      tick();
      if (fin) break;
    end
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    if (!fin) chk("run_mem_bound", 32'd0, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; ex_valid = 1'b0; alu_result_ex = '0; rs2_data_for_mem_ex = '0;
    rd_ex_out = '0; mem_write_ex_out = 1'b0; memtoreg_ex_out = 1'b0;
    mem_load_type_ex_out = 3'b000; mem_store_type_ex_out = 2'b00; wb_reg_file_ex_out = 1'b0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_req", {31'd0, dmem_req}, 32'd0);
    chk("rst_stall", {31'd0, stall_o}, 32'd0);
    chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_fwd", data_forward_mem, 32'd0);
    chk("rst_be", {28'd0, dmem_be}, 32'd0);
    rst_n = 1'b1;
    tick();

    // ADD rd=5 alu=0x1234
    issue(32'h0000_1234, 32'd0, 5'd5, 1'b0, 1'b0, 3'b000, 2'b00, 1'b1);
    #1;
    chk("add_stall", {31'd0, stall_o}, 32'd0);
    chk("add_req", {31'd0, dmem_req}, 32'd0);
    chk("add_fwd", data_forward_mem, 32'h0000_1234);
    chk("add_rd_mem", {27'd0, rd_mem}, 32'd5);
    tick();
    chk("add_wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("add_wb_we", {31'd0, wb_we}, 32'd1);
    chk("add_wb_rd", {27'd0, wb_rd}, 32'd5);
    chk("add_wb_data", wb_data, 32'h0000_1234);
    tick();
    chk("add_wb_clear", {31'd0, wb_valid}, 32'd0);

    // ADD with rd=0: retires but never writes
    issue(32'h0000_0077, 32'd0, 5'd0, 1'b0, 1'b0, 3'b000, 2'b00, 1'b1);
    tick();
    chk("rd0_wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("rd0_wb_we", {31'd0, wb_we}, 32'd0);

    // SB addr=0x103 data=0xAB, gnt after 3 cycles
    issue(32'h0000_0103, 32'h0000_00AB, 5'd0, 1'b1, 1'b0, 3'b000, 2'b00, 1'b0);
    run_mem(3, -1, 32'd0, stalls);
    chk("sb_req", {31'd0, cap_req}, 32'd1);
    chk("sb_we", {31'd0, cap_we}, 32'd1);
    chk("sb_addr", cap_addr, 32'h0000_0100);
    chk("sb_be", {28'd0, cap_be}, 32'h8);
    chk("sb_wdata", cap_wdata, 32'hABAB_ABAB);
    chk("sb_stalls", stalls, 32'd3);
    chk("sb_wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("sb_wb_we", {31'd0, wb_we}, 32'd0);
    #1;
    chk("sb_req_after", {31'd0, dmem_req}, 32'd0);

    // SH addr=0x102 data=0x1234BEEF, immediate gnt
    issue(32'h0000_0102, 32'h1234_BEEF, 5'd0, 1'b1, 1'b0, 3'b000, 2'b01, 1'b0);
    run_mem(0, -1, 32'd0, stalls);
    chk("sh_be", {28'd0, cap_be}, 32'hC);
    chk("sh_wdata", cap_wdata, 32'hBEEF_BEEF);
    chk("sh_stalls", stalls, 32'd0);

    // SW addr=0x200
    issue(32'h0000_0200, 32'hDEAD_BEEF, 5'd0, 1'b1, 1'b0, 3'b000, 2'b10, 1'b0);
    run_mem(1, -1, 32'd0, stalls);
    chk("sw_be", {28'd0, cap_be}, 32'hF);
    chk("sw_wdata", cap_wdata, 32'hDEAD_BEEF);
    chk("sw_stalls", stalls, 32'd1);

    // LB addr=0x101 rdata=0x00008000, rvalid 2 cycles after gnt
    issue(32'h0000_0101, 32'd0, 5'd7, 1'b0, 1'b1, 3'b000, 2'b00, 1'b1);
    run_mem(0, 2, 32'h0000_8000, stalls);
    chk("lb_req", {31'd0, cap_req}, 32'd1);
    chk("lb_we", {31'd0, cap_we}, 32'd0);
    chk("lb_addr", cap_addr, 32'h0000_0100);
    chk("lb_stalls", stalls, 32'd2);
    chk("lb_wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("lb_wb_we", {31'd0, wb_we}, 32'd1);
    chk("lb_wb_rd", {27'd0, wb_rd}, 32'd7);
    chk("lb_wb_data", wb_data, 32'hFFFF_FF80);

    // LBU same address, rvalid together with a one-cycle-late gnt
    issue(32'h0000_0101, 32'd0, 5'd7, 1'b0, 1'b1, 3'b100, 2'b00, 1'b1);
    run_mem(1, 0, 32'h0000_8000, stalls);
    chk("lbu_stalls", stalls, 32'd1);
    chk("lbu_wb_data", wb_data, 32'h0000_0080);

    // LH addr=0x102 rdata=0x80010000
    issue(32'h0000_0102, 32'd0, 5'd8, 1'b0, 1'b1, 3'b001, 2'b00, 1'b1);
    run_mem(0, 1, 32'h8001_0000, stalls);
    chk("lh_wb_data", wb_data, 32'hFFFF_8001);
    chk("lh_wb_we", {31'd0, wb_we}, 32'd1);

    // LHU addr=0x102
    issue(32'h0000_0102, 32'd0, 5'd8, 1'b0, 1'b1, 3'b101, 2'b00, 1'b1);
    run_mem(0, 1, 32'h8001_0000, stalls);
    chk("lhu_wb_data", wb_data, 32'h0000_8001);

    // LH addr=0x101: misaligned, dropped
    issue(32'h0000_0101, 32'd0, 5'd9, 1'b0, 1'b1, 3'b001, 2'b00, 1'b1);
    #1;
    chk("mis_req", {31'd0, dmem_req}, 32'd0);
    chk("mis_stall", {31'd0, stall_o}, 32'd0);
    tick();
    chk("mis_exc", {31'd0, misaligned_exc}, 32'd1);
    chk("mis_wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("mis_wb_we", {31'd0, wb_we}, 32'd0);
    tick();
    chk("mis_exc_pulse", {31'd0, misaligned_exc}, 32'd0);

    // LW with no response: timeout abort
    issue(32'h0000_0300, 32'd0, 5'd9, 1'b0, 1'b1, 3'b010, 2'b00, 1'b1);
    run_mem(-1, -1, 32'd0, stalls);
    chk("tmo_stalls_range", {31'd0, (stalls >= 253 && stalls <= 255)}, 32'd1);
    chk("tmo_bus_err", {31'd0, bus_err}, 32'd1);
    chk("tmo_wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("tmo_wb_we", {31'd0, wb_we}, 32'd0);
    #1;
    chk("tmo_stall_low", {31'd0, stall_o}, 32'd0);
    tick();
    chk("tmo_bus_err_pulse", {31'd0, bus_err}, 32'd0);

    // Reset while waiting for the response
    issue(32'h0000_0400, 32'd0, 5'd10, 1'b0, 1'b1, 3'b010, 2'b00, 1'b1);
    dmem_gnt = 1'b1;
    tick();
    dmem_gnt = 1'b0;
    #1;
    chk("rwait_stall", {31'd0, stall_o}, 32'd1);
    chk("rwait_req", {31'd0, dmem_req}, 32'd0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rmid_req", {31'd0, dmem_req}, 32'd0);
    chk("rmid_stall", {31'd0, stall_o}, 32'd0);
    dmem_rvalid = 1'b1; dmem_rdata = 32'hCAFE_F00D;
    tick();
    dmem_rvalid = 1'b0;
    chk("rmid_late_rvalid", {31'd0, wb_valid}, 32'd0);
    tick();
    chk("rmid_late_rvalid2", {31'd0, wb_valid}, 32'd0);

    // Pipeline still usable afterwards
    issue(32'h0000_0055, 32'd0, 5'd3, 1'b0, 1'b0, 3'b000, 2'b00, 1'b1);
    tick();
    chk("post_wb_data", wb_data, 32'h0000_0055);
    chk("post_wb_we", {31'd0, wb_we}, 32'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
